reg_bank_reader: RTL and testbench
==================================

// Module: reg_bank_reader
// PURPOSE
//  Read side of the 32-bit load-register bank. Holds NUM_REGS registers written by the
//  existing load interface (load + addr + data) and serves reads via valid/ready request
//  and response channels. Responses are buffered in a 2-entry response queue so a stalled
//  consumer never loses data. Sits between the datapath registers and any bus/debug reader.
// PARAMETERS
//  NUM_REGS   8    number of 32-bit registers in the bank (2..256)
//  DATA_W     32   register width
//  ADDR_W     8    address width; addresses >= NUM_REGS are out of range
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       reset, synchronous, active-high
//  wr_load    in   1       write strobe; 1 = write wr_data into bank[wr_addr] this edge
//  wr_addr    in   ADDR_W  write address; out-of-range writes are dropped
//  wr_data    in   DATA_W  write data
//  req_valid  in   1       read request present
//  req_ready  out  1       bank can accept a read request this cycle
//  req_addr   in   ADDR_W  read address, sampled when req_valid && req_ready
//  rsp_valid  out  1       response at head of queue is valid
//  rsp_ready  in   1       consumer accepts head response
//  rsp_data   out  DATA_W  read data of head response
//  rsp_err    out  1       head response was an out-of-range address
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all bank registers <= 0; queue emptied; rsp_valid=0,
//    rsp_data=0, rsp_err=0, req_ready=1 in the cycle after reset. wr_load and req_valid
//    are ignored during reset cycles.
//  - Write: on posedge with wr_load=1 and wr_addr<NUM_REGS, bank[wr_addr] <= wr_data.
//    Without wr_load the register holds its value indefinitely.
//  - Request accept: req_fire = req_valid && req_ready. req_ready = (count<2), no
//    same-cycle bypass: a full queue deasserts req_ready even when rsp_ready=1.
//  - Latency: request accepted at edge N -> response visible at queue head (rsp_valid=1)
//    in the cycle after edge N if the queue was empty; else behind the older entries.
//  - Read data is the bank content before edge N. Read and write to the same address
//    in the same cycle returns the OLD value; the new value is seen from the next request.
//  - Out of range (req_addr>=NUM_REGS): entry pushed with data=0, err=1; still consumes
//    one queue slot and follows normal ordering.
//  - Response pop: rsp_fire = rsp_valid && rsp_ready; head advances at the edge.
//    Simultaneous push and pop with count==1: count stays 1, new entry becomes head.
//  - Ordering: responses strictly in request order; no entry dropped or duplicated.
//  - Stall: while rsp_valid=1 && rsp_ready=0, rsp_data/rsp_err are held stable.
//  - Empty queue: rsp_valid=0, rsp_data=0, rsp_err=0.
//  - Reset mid-operation: queued responses discarded, not delivered; bank cleared.
//  - Queue count: 2-bit, range 0..2; states EMPTY(0) -> ONE(1) -> FULL(2).
//    Transitions: push only +1, pop only -1, push+pop hold; push at FULL impossible.
// STRUCTURE
//  - reg_bank_pkg: DATA_W/ADDR_W defaults, typedef rsp_t {logic err; logic [DATA_W-1:0]
//    data;}, function in_range(addr, NUM_REGS).
//  - One sub-module: rsp_fifo2 (2-entry FIFO of rsp_t, push/pop/count/full/empty, sync
//    active-high rst). Top holds the bank array, write decode, read mux and req_ready.
// TESTING
//  1. Reset then write bank[3]=0xDEADBEEF; read addr 3 with rsp_ready=1 -> one cycle
//     later rsp_valid=1, rsp_data=0xDEADBEEF, rsp_err=0.
//  2. Same-cycle wr_load addr 5=0x1234 and read addr 5 (old 0) -> rsp_data=0; next
//     read of addr 5 -> 0x00001234.
//  3. rsp_ready=0, issue reads 0,1,2 back-to-back -> 2 accepted, req_ready=0 on third;
//     release rsp_ready -> data of addr 0 then 1, in order, held stable during stall.
//  4. NUM_REGS=8, read addr 9 -> rsp_err=1, rsp_data=0; next read addr 2 -> err=0.
//  5. Queue holds 2 entries, assert rst for one cycle -> rsp_valid=0, all reads return 0.
//  6. Continuous req_valid and rsp_ready=1 over addrs 0..7 -> one response per cycle
//     after first, count toggling 1, no bubbles.

Source files
------------

// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the load-register bank read path.
// Contents:
//    DATA_W, ADDR_W   register width and address width used by every file
//    rsp_t            one queued read response (error flag + read data)
//    fifo_state_e     occupancy of the two-entry response queue
//    in_range()       true when an address selects an existing bank register
package reg_bank_reader_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   // A response carries its data and a flag for out-of-range requests.
   // Out-of-range responses always carry zero data.
   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] data;
   } rsp_t;

   // The queue state doubles as the 2-bit occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } fifo_state_e;

   // Addresses at or above the bank size do not select a register.
   function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int numRegs);
      return int'(addr) < numRegs;
   endfunction

endpackage

// File: rtl/reg_bank_reader_if.sv
// Bundle of the write-load and read request/response signals of the bank.
// Signals:
//    wr_load, wr_addr, wr_data      load-register write port
//    req_valid, req_ready, req_addr read request channel
//    rsp_valid, rsp_ready           read response channel handshake
//    rsp_data, rsp_err              head-of-queue response contents
// Modports:
//    master   the requester (drives writes, requests, and response acceptance)
//    slave    the register bank itself
interface reg_bank_reader_if;
   import reg_bank_reader_pkg::*;

   logic              wr_load;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output wr_load, wr_addr, wr_data,
      output req_valid, req_addr,
      input  req_ready,
      input  rsp_valid, rsp_data, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  wr_load, wr_addr, wr_data,
      input  req_valid, req_addr,
      output req_ready,
      output rsp_valid, rsp_data, rsp_err,
      input  rsp_ready
   );

endinterface

// File: rtl/reg_bank_reader_rsp_fifo2.sv
// Two-entry response queue for the register bank reader.
// Ports:
//    clk          clock, all updates on the rising edge
//    rst          synchronous active-high reset, empties the queue
//    push_i       write pushData_i behind existing entries (ignored when full)
//    pushData_i   response to enqueue
//    pop_i        drop the head entry (ignored when empty)
//    head_o       head entry; all zeros whenever the queue is empty
//    count_o      occupancy 0..2
//    full_o       two entries held
//    empty_o      no entries held
module rsp_fifo2
   import reg_bank_reader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  rsp_t        pushData_i,
   input  logic        pop_i,
   output rsp_t        head_o,
   output logic [1:0]  count_o,
   output logic        full_o,
   output logic        empty_o
);

   fifo_state_e state_q;
   rsp_t        head_q;
   rsp_t        tail_q;

   // Occupancy FSM with the two storage slots. The head slot is always the
   // oldest entry and is cleared whenever the queue drains, so the head output
   // reads as zero when empty without any extra masking. A push together with
   // a pop at one entry replaces the head directly; at FULL the tail moves up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push_i) begin
                  head_q  <= pushData_i;
                  state_q <= ONE;
               end
            end
            ONE: begin
               if (push_i && pop_i) begin
                  head_q <= pushData_i;
               end else if (push_i) begin
                  tail_q  <= pushData_i;
                  state_q <= FULL;
               end else if (pop_i) begin
                  head_q  <= '0;
                  state_q <= EMPTY;
               end
            end
            FULL: begin
               if (pop_i) begin
                  head_q  <= tail_q;
                  tail_q  <= '0;
                  state_q <= ONE;
               end
            end
            default: begin
               state_q <= EMPTY;
               head_q  <= '0;
               tail_q  <= '0;
            end
         endcase
      end
   end

   // Status is taken straight from the registered state.
   assign head_o  = head_q;
   assign count_o = state_q;
   assign full_o  = (state_q == FULL);
   assign empty_o = (state_q == EMPTY);

endmodule

// File: rtl/reg_bank_reader.sv
// Read side of the load-register bank.
// Holds NUM_REGS registers written through the load port and answers read
// requests through a valid/ready request channel and a two-entry buffered
// response channel, so a stalled consumer never loses a response.
// Ports:
//    clk    clock, all state updates on the rising edge
//    rst    synchronous active-high reset; clears the bank and the queue
//    bus    reg_bank_reader_if.slave: load port, request and response channels
// Widths come from reg_bank_reader_pkg (DATA_W, ADDR_W).
module reg_bank_reader
   import reg_bank_reader_pkg::*;
#(
   parameter int NUM_REGS = 8
) (
   input  logic              clk,
   input  logic              rst,
   reg_bank_reader_if.slave  bus
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] bank_q [NUM_REGS];
   rsp_t              rsp_d;
   rsp_t              fifoHead;
   logic [1:0]        fifoCount;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              reqFire;
   logic              rspFire;

   // Bank write port. Out-of-range addresses are dropped; reset takes
   // priority over any load in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank_q[i] <= '0;
         end
      end else if (bus.wr_load && in_range(bus.wr_addr, NUM_REGS)) begin
         bank_q[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
      end
   end

   // Read mux for the incoming request. It looks at the registered bank, so a
   // load to the same address in the same cycle is not yet visible and the
   // old contents are returned. Out-of-range reads become zero data with err.
   always_comb begin
      rsp_d = '0;
      if (in_range(bus.req_addr, NUM_REGS)) begin
         rsp_d.data = bank_q[bus.req_addr[IDX_W-1:0]];
      end else begin
         rsp_d.err = 1'b1;
      end
   end

   // Requests are accepted only while a queue slot is free right now; a pop
   // in the same cycle does not open a slot early.
   assign reqFire = bus.req_valid && !fifoFull;
   assign rspFire = bus.rsp_ready && !fifoEmpty;

   rsp_fifo2 u_rspFifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (reqFire),
      .pushData_i (rsp_d),
      .pop_i      (rspFire),
      .head_o     (fifoHead),
      .count_o    (fifoCount),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty)
   );

   assign bus.req_ready = !fifoFull;
   assign bus.rsp_valid = (fifoCount != 2'd0);
   assign bus.rsp_data  = fifoHead.data;
   assign bus.rsp_err   = fifoHead.err;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Testbench for reg_bank_reader: directed scenarios followed by random
// traffic, checked by a scoreboard fed from a behavioural bank model.
module tb_reg_bank_reader;
   import reg_bank_reader_pkg::*;

   localparam int NUM_REGS = 8;

   logic clk;
   logic rst;

   reg_bank_reader_if bus ();

   reg_bank_reader #(.NUM_REGS(NUM_REGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;

   logic [31:0] mdl [NUM_REGS];
   rsp_t        expQ [$];
   int          modelCount  = 0;
   bit          pendPush    = 0;
   bit          pendPop     = 0;
   bit          pendRst     = 1;
   bit          monEnable   = 0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; every check steps the shared counters.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One clock cycle of stimulus. At the falling edge the model occupancy is
   // advanced by what happened at the previous rising edge and the handshake
   // outputs are checked against it; then the new inputs are driven and any
   // request that will be accepted has its answer queued from the model bank
   // as it stands before this cycle's write.
   task automatic applyStimulus(input bit wrLoad, input logic [7:0] wrAddr, input logic [31:0] wrData,
                                input bit reqValid, input logic [7:0] reqAddr,
                                input bit rspReady, input bit rstIn);
      rsp_t e;
      @(negedge clk);
      if (pendRst) modelCount = 0;
      else         modelCount = modelCount + int'(pendPush) - int'(pendPop);
      checkOutput("req_ready", {31'b0, bus.req_ready}, {31'b0, (modelCount < 2)});
      checkOutput("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, (modelCount > 0)});

      rst           = rstIn;
      bus.wr_load   = wrLoad;
      bus.wr_addr   = wrAddr;
      bus.wr_data   = wrData;
      bus.req_valid = reqValid;
      bus.req_addr  = reqAddr;
      bus.rsp_ready = rstIn ? 1'b0 : rspReady;
      pendRst       = rstIn;

      if (rstIn) begin
         foreach (mdl[i]) mdl[i] = '0;
         expQ.delete();
         pendPush = 0;
         pendPop  = 0;
      end else begin
         pendPop  = rspReady && (modelCount > 0);
         pendPush = reqValid && (modelCount < 2);
         if (pendPush) begin
            if (int'(reqAddr) < NUM_REGS) begin
               e.err  = 1'b0;
               e.data = mdl[reqAddr];
            end else begin
               e.err  = 1'b1;
               e.data = '0;
            end
            expQ.push_back(e);
         end
         if (wrLoad && (int'(wrAddr) < NUM_REGS)) mdl[wrAddr] = wrData;
      end
   endtask

   // Monitor: shortly after each falling edge, compare the head response
   // against the scoreboard whenever it is being consumed, check that stalled
   // responses stay put and that an empty queue presents zeros.
   initial begin : monitor
      bit          prevStall = 0;
      logic [31:0] heldData  = '0;
      logic        heldErr   = 1'b0;
      rsp_t        exp;
      forever begin
         @(negedge clk);
         #2;
         if (monEnable) begin
            if (prevStall) begin
               checkOutput("stall_data", bus.rsp_data, heldData);
               checkOutput("stall_err", {31'b0, bus.rsp_err}, {31'b0, heldErr});
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
               if (expQ.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL unexpected_rsp: got data 0x%08h err %0b, expected no response",
                           bus.rsp_data, bus.rsp_err);
               end else begin
                  exp = expQ.pop_front();
                  checkOutput("rsp_data", bus.rsp_data, exp.data);
                  checkOutput("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp.err});
               end
            end else if (bus.rsp_valid !== 1'b1) begin
               checkOutput("empty_data", bus.rsp_data, 32'h0);
               checkOutput("empty_err", {31'b0, bus.rsp_err}, 32'h0);
            end
            prevStall = (bus.rsp_valid === 1'b1) && (bus.rsp_ready === 1'b0) && (rst === 1'b0);
            heldData  = bus.rsp_data;
            heldErr   = bus.rsp_err;
         end
      end
   end

   // Main sequence: reset, directed scenarios, random traffic, drain, summary.
   initial begin : stimulus
      logic [7:0] rAddr;
      rst           = 1'b1;
      bus.wr_load   = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      monEnable = 1;
      pendRst   = 1;

      $display("[TB] directed: write then read");
      applyStimulus(1, 8'd3, 32'hDEADBEEF, 0, 8'd0, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd3, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] directed: same-cycle write and read");
      applyStimulus(1, 8'd5, 32'h00001234, 1, 8'd5, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd5, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] directed: stalled consumer");
      applyStimulus(1, 8'd0, 32'hA0A0A0A0, 0, 8'd0, 0, 0);
      applyStimulus(1, 8'd1, 32'hB1B1B1B1, 0, 8'd0, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd0, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd1, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd2, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] directed: out-of-range read");
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd9, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd2, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd255, 1, 0);
      applyStimulus(1, 8'd8, 32'hFFFFFFFF, 0, 8'd0, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] directed: reset with queued responses");
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd3, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 1, 8'd5, 0, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 0, 1);
      for (int a = 0; a < NUM_REGS; a++) begin
         applyStimulus(0, 8'd0, 32'h0, 1, 8'(a), 1, 0);
      end
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] directed: streaming reads");
      for (int a = 0; a < NUM_REGS; a++) begin
         applyStimulus(1, 8'(a), 32'h11110000 + 32'(a), 0, 8'd0, 1, 0);
      end
      for (int a = 0; a < NUM_REGS; a++) begin
         applyStimulus(0, 8'd0, 32'h0, 1, 8'(a), 1, 0);
      end
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         rAddr = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
         applyStimulus($urandom_range(0, 1) == 1, 8'($urandom_range(0, 9)), $urandom,
                       $urandom_range(0, 3) != 0, rAddr,
                       $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      end

      for (int k = 0; k < 20 && (expQ.size() > 0 || pendPush); k++) begin
         applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);
      end
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);
      applyStimulus(0, 8'd0, 32'h0, 0, 8'd0, 1, 0);
      checkOutput("drain_left", 32'(expQ.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
